// File: rtl/rr_scan_arbiter.sv
// ---------------------------------------------------------------------------
// rr_scan_arbiter
//   Round-robin arbiter sharing one downstream resource among 8 requesters.
//   A rotating 3-bit pointer names the highest-priority requester. Grants are
//   registered, one-hot (GNT_8) plus binary index (GNT_IDX), and limited to
//   MAX_HOLD consecutive cycles. Every grant is followed by one all-zero
//   cycle in which the next arbitration takes place.
//
// Parameters
//   MAX_HOLD : maximum consecutive cycles of one grant (1..15)
//   HOLD_W   : width of the hold counter (must be able to hold MAX_HOLD)
//
// Ports
//   CLK     in   1  clock, all state updates on posedge
//   RST     in   1  synchronous active-high reset
//   REQ_8   in   8  level requests, bit i = requester i
//   GNT_8   out  8  registered one-hot grant, zero when no grant
//   GNT_IDX out  3  index of current grant, last granted index when idle
//   VALID   out  1  grant active
//   PTR     out  3  highest-priority index for the next arbitration
// ---------------------------------------------------------------------------
module rr_scan_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] REQ_8,
    output logic [7:0] GNT_8,
    output logic [2:0] GNT_IDX,
    output logic       VALID,
    output logic [2:0] PTR
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    logic [0:0]        state_q, state_d;
    logic [7:0]        gnt_q, gnt_d;
    logic [2:0]        gnt_idx_q, gnt_idx_d;
    logic              valid_q, valid_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // Requests rotated so that bit 0 is the requester at PTR; the first set
    // bit from the bottom is then the round-robin winner.
    logic [7:0] req_rot;
    logic [2:0] sel_ofs;
    logic [2:0] sel_idx;
    logic [7:0] sel_onehot;

    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
        localparam logic [2:0] OFS = 3'(gi);
        // 3-bit addition wraps mod 8, giving the circular scan order.
        assign req_rot[gi]    = REQ_8[ptr_q + OFS];
        assign sel_onehot[gi] = (sel_idx == OFS);
    end

    always_comb begin
        sel_ofs = 3'd0;
        // Descending loop so the lowest set offset wins.
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_ofs = 3'(i);
            end
        end
    end

    assign sel_idx = ptr_q + sel_ofs;

    logic release_now;
    assign release_now = !REQ_8[gnt_idx_q] || (hold_q == MAX_HOLD_C);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ_8 != 8'd0) begin
                    state_d   = ST_GRANT;
                    gnt_d     = sel_onehot;
                    gnt_idx_d = sel_idx;
                    valid_d   = 1'b1;
                    hold_d    = HOLD_ONE;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    // Request drop and hold-limit on the same edge collapse
                    // into this single release, so PTR advances once.
                    state_d = ST_IDLE;
                    gnt_d   = 8'd0;
                    valid_d = 1'b0;
                    ptr_d   = gnt_idx_q + 3'd1;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 8'd0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 8'd0;
            gnt_idx_q <= 3'd0;
            valid_q   <= 1'b0;
            ptr_q     <= 3'd0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign GNT_8   = gnt_q;
    assign GNT_IDX = gnt_idx_q;
    assign VALID   = valid_q;
    assign PTR     = ptr_q;

endmodule

// File: tb/tb_rr_scan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_scan_arbiter
//   Two arbiters (MAX_HOLD=4 and MAX_HOLD=3) share the same REQ/RST stimulus.
//   A behavioural model per instance predicts GNT_8, GNT_IDX, VALID and PTR
//   every cycle. Directed sequences cover reset, single requester, round
//   robin, wrap, reset mid-grant and simultaneous release events; a random
//   phase follows.
// ---------------------------------------------------------------------------
module tb_rr_scan_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       valid_a, valid_b;
    logic [2:0] ptr_a, ptr_b;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = MAX_HOLD 4 instance, index 1 = MAX_HOLD 3.
    int m_valid [2];
    int m_idx   [2];
    int m_ptr   [2];
    int m_hold  [2];
    int m_max   [2];

    rr_scan_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut_a (
        .CLK(clk), .RST(rst), .REQ_8(req),
        .GNT_8(gnt_a), .GNT_IDX(idx_a), .VALID(valid_a), .PTR(ptr_a)
    );

    rr_scan_arbiter #(.MAX_HOLD(3), .HOLD_W(4)) dut_b (
        .CLK(clk), .RST(rst), .REQ_8(req),
        .GNT_8(gnt_b), .GNT_IDX(idx_b), .VALID(valid_b), .PTR(ptr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one arbiter model by one clock edge using the sampled inputs.
    task automatic model_edge(input int n, input logic r, input logic [7:0] rq);
        if (r) begin
            m_valid[n] = 0; m_idx[n] = 0; m_ptr[n] = 0; m_hold[n] = 0;
        end else if (m_valid[n] == 0) begin
            if (rq != 8'd0) begin
                for (int k = 0; k < 8; k++) begin
                    int cand;
                    cand = (m_ptr[n] + k) % 8;
                    if (rq[cand]) begin
                        m_idx[n]   = cand;
                        m_valid[n] = 1;
                        m_hold[n]  = 1;
                        if (n == 0) $display("grant inst%0d idx=%0d ptr=%0d", n, cand, m_ptr[n]);
                        break;
                    end
                end
            end
        end else begin
            if (!rq[m_idx[n]] || m_hold[n] == m_max[n]) begin
                m_valid[n] = 0;
                m_ptr[n]   = (m_idx[n] + 1) % 8;
                m_hold[n]  = 0;
            end else begin
                m_hold[n] = m_hold[n] + 1;
            end
        end
    endtask

    task automatic compare_all();
        int exp_gnt;
        exp_gnt = m_valid[0] ? (1 << m_idx[0]) : 0;
        check("a_gnt",   int'(gnt_a),   exp_gnt);
        check("a_idx",   int'(idx_a),   m_idx[0]);
        check("a_valid", int'(valid_a), m_valid[0]);
        check("a_ptr",   int'(ptr_a),   m_ptr[0]);
        exp_gnt = m_valid[1] ? (1 << m_idx[1]) : 0;
        check("b_gnt",   int'(gnt_b),   exp_gnt);
        check("b_idx",   int'(idx_b),   m_idx[1]);
        check("b_valid", int'(valid_b), m_valid[1]);
        check("b_ptr",   int'(ptr_b),   m_ptr[1]);
    endtask

    // One clock: update models with pre-edge inputs, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge(0, rst, req);
        model_edge(1, rst, req);
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        m_max[0] = 4;
        m_max[1] = 3;
        for (int n = 0; n < 2; n++) begin
            m_valid[n] = 0; m_idx[n] = 0; m_ptr[n] = 0; m_hold[n] = 0;
        end

        // 1. Reset with all requests active.
        rst = 1'b1;
        req = 8'hFF;
        steps(2);
        check("rst_valid", int'(valid_a), 0);
        check("rst_ptr",   int'(ptr_a),   0);
        rst = 1'b0;
        step();
        check("first_grant_idx", int'(idx_a), 0);
        check("first_grant_gnt", int'(gnt_a), 1);
        req = 8'h00;
        steps(2);

        // 2. Single requester for two cycles.
        req = 8'b0000_0100;
        steps(2);
        check("single_gnt", int'(gnt_a), 4);
        req = 8'h00;
        step();
        check("single_valid", int'(valid_a), 0);
        check("single_ptr",   int'(ptr_a),   3);
        steps(2);

        // 3. Round robin over odd requesters.
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'b1010_1010;
        step();
        check("rr_first_idx", int'(idx_a), 1);
        steps(4);
        check("rr_ptr1", int'(ptr_a), 2);
        step();
        check("rr_second_idx", int'(idx_a), 3);
        steps(30);
        req = 8'h00;
        steps(6);

        // 4. Wrap: grant idx 5 and drop it to leave PTR at 6.
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'b0010_0000;
        steps(2);
        req = 8'h00;
        step();
        check("wrap_ptr6", int'(ptr_a), 6);
        req = 8'b0000_0011;
        step();
        check("wrap_idx0", int'(idx_a), 0);
        steps(12);
        req = 8'h00;
        steps(6);

        // 5. Reset while idx 5 is granted.
        req = 8'b1010_0000;
        rst = 1'b1; step(); rst = 1'b0;
        step();
        check("mid_pre_idx", int'(idx_a), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_valid", int'(valid_a), 0);
        check("mid_ptr",   int'(ptr_a),   0);
        step();
        check("mid_next_idx", int'(idx_a), 5);
        req = 8'h00;
        steps(6);

        // 6. Requester 4 drops on its 3rd grant cycle while 6 requests.
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'b0001_0000;
        steps(3);
        req = 8'b0100_0000;
        step();
        check("sim_valid", int'(valid_b), 0);
        check("sim_ptr",   int'(ptr_b),   5);
        step();
        check("sim_next_idx", int'(idx_b), 6);
        req = 8'h00;
        steps(6);

        // Random phase: requests persist a few cycles, occasional resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            if ($urandom_range(0, 9) == 0) req = req & 8'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
